// File: rtl/ram_arbiter.sv
// Two-requester arbiter sharing one single-port RAM through an IDLE/ACCESS/DONE sequence.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 always wins ties.
module ram_arbiter #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wd0,
   input  logic [DATA_W-1:0] wd1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rd0,
   output logic [DATA_W-1:0] rd1,
   output logic              ram_r,
   output logic              ram_w,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_d,
   input  logic [DATA_W-1:0] ram_o,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state_q;
   logic                owner_q;
   logic                gnt0_q, gnt1_q, ack0_q, ack1_q;
   logic                ram_r_q, ram_w_q, busy_q;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic [DATA_W-1:0]   ram_d_q, rd0_q, rd1_q;

   logic                win_d;
   logic                we_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wd_d;

`ifdef ARB_ROUND_ROBIN_EN
   // last_q names the requester granted most recently; the other one wins a tie.
   logic                last_q;

   always_comb begin
      win_d = 1'b0;
      if (req0 && req1) begin
         win_d = ~last_q;
      end else if (req1) begin
         win_d = 1'b1;
      end
   end
`else
   always_comb begin
      win_d = 1'b0;
      if (!req0 && req1) begin
         win_d = 1'b1;
      end
   end
`endif

   always_comb begin
      we_d   = win_d ? we1   : we0;
      addr_d = win_d ? addr1 : addr0;
      wd_d   = win_d ? wd1   : wd0;
   end

   // The RAM address/data registers double as the latched request, so they hold between accesses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         ram_r_q    <= 1'b0;
         ram_w_q    <= 1'b0;
         busy_q     <= 1'b0;
         ram_addr_q <= '0;
         ram_d_q    <= '0;
         rd0_q      <= '0;
         rd1_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q     <= 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  state_q    <= ACCESS;
                  owner_q    <= win_d;
                  gnt0_q     <= ~win_d;
                  gnt1_q     <= win_d;
                  ram_w_q    <= we_d;
                  ram_r_q    <= ~we_d;
                  ram_addr_q <= addr_d;
                  ram_d_q    <= wd_d;
                  busy_q     <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                  last_q     <= win_d;
`endif
               end
            end
            ACCESS: begin
               state_q <= DONE;
               ram_r_q <= 1'b0;
               ram_w_q <= 1'b0;
               ack0_q  <= ~owner_q;
               ack1_q  <= owner_q;
               if (ram_r_q) begin
                  if (owner_q) begin
                     rd1_q <= ram_o;
                  end else begin
                     rd0_q <= ram_o;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rd0      = rd0_q;
   assign rd1      = rd1_q;
   assign ram_r    = ram_r_q;
   assign ram_w    = ram_w_q;
   assign ram_addr = ram_addr_q;
   assign ram_d    = ram_d_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small behavioural RAM attached.
// Arbitration expectations follow whether ARB_ROUND_ROBIN_EN is defined for the build.
module tb_ram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [2:0]  addr0, addr1;
   logic [15:0] wd0, wd1;
   logic        gnt0, gnt1, ack0, ack1;
   logic [15:0] rd0, rd1;
   logic        ram_r, ram_w;
   logic [2:0]  ram_addr;
   logic [15:0] ram_d;
   logic [15:0] ram_o;
   logic        busy;

   logic [15:0] mem [0:7];
   int          checkCount;
   int          errorCount;

   ram_arbiter #(.ADDR_W(3), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rd0(rd0), .rd1(rd1), .ram_r(ram_r), .ram_w(ram_w),
      .ram_addr(ram_addr), .ram_d(ram_d), .ram_o(ram_o), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM contents restart at word i = i * 16'h1111 on every reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'(i) * 16'h1111;
      end else if (ram_w) begin
         mem[ram_addr] <= ram_d;
      end
   end

   assign ram_o = mem[ram_addr];

   task automatic doReset();
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      doReset();
      @(negedge clk);
      checkCount++;
      if ({gnt0, gnt1, ack0, ack1, ram_r, ram_w, busy} !== 7'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {gnt0, gnt1, ack0, ack1, ram_r, ram_w, busy});
      end
      checkCount++;
      if ({ram_addr, ram_d, rd0, rd1} !== 51'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_data: addr=%h d=%h rd0=%h rd1=%h expected all 0", ram_addr, ram_d, rd0, rd1);
      end
   endtask

   task automatic test_write();
      req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; wd0 = 16'hA5A5;
      @(negedge clk);
      checkCount++;
      if ({ram_w, ram_r, gnt0, gnt1, ack0, busy} !== 6'b101001) begin
         errorCount++;
         $display("[TB] FAIL write_access_ctrl: got w,r,g0,g1,a0,busy=%b expected 101001", {ram_w, ram_r, gnt0, gnt1, ack0, busy});
      end
      checkCount++;
      if (ram_addr !== 3'd5 || ram_d !== 16'hA5A5) begin
         errorCount++;
         $display("[TB] FAIL write_access_bus: got addr=%0d d=%h expected addr=5 d=a5a5", ram_addr, ram_d);
      end
      @(negedge clk);
      checkCount++;
      if ({ram_w, ram_r, gnt0, gnt1, ack0, ack1} !== 6'b001010) begin
         errorCount++;
         $display("[TB] FAIL write_done_ctrl: got w,r,g0,g1,a0,a1=%b expected 001010", {ram_w, ram_r, gnt0, gnt1, ack0, ack1});
      end
      req0 = 1'b0;
      @(negedge clk);
      checkCount++;
      if ({gnt0, gnt1, ack0, busy} !== 4'b0000 || ram_addr !== 3'd5 || ram_d !== 16'hA5A5) begin
         errorCount++;
         $display("[TB] FAIL write_idle: got g0,g1,a0,busy=%b addr=%0d d=%h expected 0000 5 a5a5", {gnt0, gnt1, ack0, busy}, ram_addr, ram_d);
      end
   endtask

   task automatic test_read();
      req1 = 1'b1; we1 = 1'b0; addr1 = 3'd5;
      @(negedge clk);
      checkCount++;
      if ({ram_r, ram_w, gnt1, gnt0, ack1} !== 5'b10100 || ram_addr !== 3'd5) begin
         errorCount++;
         $display("[TB] FAIL read_access: got r,w,g1,g0,a1=%b addr=%0d expected 10100 5", {ram_r, ram_w, gnt1, gnt0, ack1}, ram_addr);
      end
      @(negedge clk);
      checkCount++;
      if ({ram_r, ack1, ack0} !== 3'b010 || rd1 !== 16'hA5A5) begin
         errorCount++;
         $display("[TB] FAIL read_done: got r,a1,a0=%b rd1=%h expected 010 a5a5", {ram_r, ack1, ack0}, rd1);
      end
      checkCount++;
      if (rd0 !== 16'h0000) begin
         errorCount++;
         $display("[TB] FAIL read_rd0_untouched: got %h expected 0000", rd0);
      end
      req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_arbitration();
      int ackCycle[$];
      int ackOwner[$];
      bit sawGnt1;
      int expOwner;
      sawGnt1 = 1'b0;
      doReset();
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 3'd1; addr1 = 3'd3;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (gnt1) sawGnt1 = 1'b1;
         checkCount++;
         if ((gnt0 && gnt1) || (ack0 && ack1) || (ram_r && ram_w)) begin
            errorCount++;
            $display("[TB] FAIL arb_exclusive: cycle %0d got g=%b%b a=%b%b rw=%b%b expected at most one of each", cyc, gnt0, gnt1, ack0, ack1, ram_r, ram_w);
         end
         if (ack0 || ack1) begin
            ackCycle.push_back(cyc);
            ackOwner.push_back(ack1 ? 1 : 0);
         end
         if (ackCycle.size() == 4) begin
            req0 = 1'b0; req1 = 1'b0;
         end
      end
      checkCount++;
      if (ackCycle.size() != 4) begin
         errorCount++;
         $display("[TB] FAIL arb_ack_count: got %0d expected 4", ackCycle.size());
      end
      for (int i = 0; i < ackCycle.size() && i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         expOwner = i % 2;
`else
         expOwner = 0;
`endif
         checkCount++;
         if (ackCycle[i] != 2 + 3 * i || ackOwner[i] != expOwner) begin
            errorCount++;
            $display("[TB] FAIL arb_order[%0d]: got cycle %0d owner %0d expected cycle %0d owner %0d", i, ackCycle[i], ackOwner[i], 2 + 3 * i, expOwner);
         end
      end
`ifndef ARB_ROUND_ROBIN_EN
      checkCount++;
      if (sawGnt1) begin
         errorCount++;
         $display("[TB] FAIL arb_fixed_gnt1: got gnt1 seen=1 expected 0");
      end
`endif
   endtask

   task automatic test_reset_during_access();
      doReset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 3'd6; wd0 = 16'hBEEF;
      @(negedge clk);
      checkCount++;
      if (ram_w !== 1'b1 || busy !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL rstacc_pre: got ram_w=%b busy=%b expected 1 1", ram_w, busy);
      end
      req0 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkCount++;
      if ({ram_w, ram_r, gnt0, ack0, busy} !== 5'b0 || ram_addr !== 3'd0 || ram_d !== 16'h0) begin
         errorCount++;
         $display("[TB] FAIL rstacc_async: got w,r,g0,a0,busy=%b addr=%0d d=%h expected 00000 0 0000", {ram_w, ram_r, gnt0, ack0, busy}, ram_addr, ram_d);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkCount++;
         if (ack0 !== 1'b0 || busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL rstacc_noack[%0d]: got ack0=%b busy=%b expected 0 0", i, ack0, busy);
         end
      end
   endtask

   task automatic test_req_drop();
      doReset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2;
      @(negedge clk);
      checkCount++;
      if (gnt0 !== 1'b1 || ram_r !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL drop_grant: got gnt0=%b ram_r=%b expected 1 1", gnt0, ram_r);
      end
      req0 = 1'b0;
      @(negedge clk);
      checkCount++;
      if (ack0 !== 1'b1 || rd0 !== 16'h2222) begin
         errorCount++;
         $display("[TB] FAIL drop_ack: got ack0=%b rd0=%h expected 1 2222", ack0, rd0);
      end
      @(negedge clk);
      @(negedge clk);
      checkCount++;
      if ({ack0, gnt0, busy} !== 3'b000 || rd0 !== 16'h2222) begin
         errorCount++;
         $display("[TB] FAIL drop_idle: got a0,g0,busy=%b rd0=%h expected 000 2222", {ack0, gnt0, busy}, rd0);
      end
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      test_reset();
      test_write();
      test_read();
      test_arbitration();
      test_reset_during_access();
      test_req_drop();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameters ADDR_W, default 3, RAM word-address width; and DATA_W, default 16, RAM word width.
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state changing on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have ports req0/req1, input, 1 each: a requester access request, held high until its ack.
REQ-005 The block SHALL have ports we0/we1, input, 1 each: 1 = write, 0 = read, sampled at grant.
REQ-006 The block SHALL have ports addr0/addr1, input, ADDR_W each: the requester word address, sampled at grant.
REQ-007 The block SHALL have ports wd0/wd1, input, DATA_W each: the requester write data, sampled at grant.
REQ-008 The block SHALL have ports gnt0/gnt1, output, 1 each: high while that requester owns the RAM.
REQ-009 The block SHALL have ports ack0/ack1, output, 1 each: a one-cycle completion pulse.
REQ-010 The block SHALL have ports rd0/rd1, output, DATA_W each: registered read data, valid while the ack is high and held until the next read for that requester.
REQ-011 The block SHALL have ports ram_r and ram_w, output, 1 each: the RAM read and write strobes.
REQ-012 The block SHALL have port ram_addr, output, ADDR_W, and port ram_d, output, DATA_W: the address and write data driven to the RAM.
REQ-013 The block SHALL have port ram_o, input, DATA_W: the RAM read data.
REQ-014 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, ACCESS and DONE.
REQ-016 In IDLE, if either req is high at a clock edge, the block SHALL:
- select a winner per REQ-022;
- latch the winner's we, addr and wd;
- set the winner's gnt;
- go to ACCESS.
REQ-017 In ACCESS, the block SHALL drive ram_addr and ram_d from the latched values, with ram_w = latched we and ram_r = NOT latched we, for exactly one cycle, then go to DONE.
REQ-018 On the ACCESS-to-DONE edge of a read, the block SHALL capture ram_o into the winner's rd register; a write SHALL leave rd unchanged.
REQ-019 In DONE, the block SHALL:
- pulse the winner's ack for one cycle;
- keep its gnt high;
- deassert ram_r and ram_w;
- go to IDLE on the next edge.
REQ-020 Latency SHALL be 2 cycles from the edge that samples req to the ack cycle; maximum throughput SHALL be one access per 3 cycles.
REQ-021 Outside ACCESS, ram_r and ram_w SHALL be 0 and ram_addr and ram_d SHALL hold their last values.
REQ-022 When both reqs are high in IDLE:
- with ARB_ROUND_ROBIN_EN defined, the requester not granted most recently SHALL win;
- without it, requester 0 SHALL always win.
REQ-023 When only one req is high in IDLE, that requester SHALL win regardless of priority.
REQ-024 A req deasserted after grant SHALL NOT abort the transaction; the ack SHALL still be issued.
REQ-025 A req arriving during ACCESS or DONE SHALL be considered only in the following IDLE.
REQ-026 At most one gnt, one ack and one of ram_r/ram_w SHALL be high in any cycle.

Reset
REQ-027 While rst_n is low, the block SHALL immediately (asynchronously) force the following, regardless of the clock:
- state = IDLE;
- gnt0/gnt1, ack0/ack1, ram_r, ram_w and busy = 0;
- ram_addr, ram_d, rd0 and rd1 = 0;
- last-granted pointer = 1, so requester 0 wins the first tie.
REQ-028 A reset asserted during ACCESS or DONE SHALL abandon the transaction without any ack, and the strobes SHALL drop in the same cycle.
REQ-029 After rst_n rises, the first arbitration SHALL occur at the first clock edge at which a req is high.

Configuration
REQ-030 The macro ARB_ROUND_ROBIN_EN, when defined, SHALL compile in round-robin arbitration and the last-granted pointer (updated at every grant).
REQ-031 When ARB_ROUND_ROBIN_EN is undefined, the block SHALL compile in fixed priority with requester 0 highest and SHALL include no pointer register.

Verification
REQ-032 The bench SHALL cover: reset, then req0=1, we0=1, addr0=5, wd0=16'hA5A5 -> ram_w=1 with ram_addr=5 and ram_d=16'hA5A5 for one cycle, ack0 2 cycles after sampling, gnt1 stays 0.
REQ-033 The bench SHALL cover: a read of address 5 by requester 1 after that write, with the RAM model returning 16'hA5A5 -> ram_r=1 for one cycle, then ack1=1 with rd1=16'hA5A5.
REQ-034 The bench SHALL cover: req0 and req1 held high continuously with round robin enabled -> grant order 0,1,0,1, with acks 3 cycles apart.
REQ-035 The bench SHALL cover: the same stimulus with the macro undefined -> requester 0 granted every time and requester 1 never granted.
REQ-036 The bench SHALL cover: rst_n low during ACCESS of a write -> ram_w drops immediately, no ack, busy=0, state IDLE.
REQ-037 The bench SHALL cover: req0 dropped in the cycle after grant -> the access completes and ack0 still pulses.
